rotary_value_ctrl: RTL and testbench

Controller between rotary_decoder and the LCD text writer. Turns inc_pulse/dec_pulse into a bounded setpoint value. Coalesces bursts of rotation. Issues one req/ack display-update transaction per settled change, so the I2C LCD path is never flooded by encoder pulses.

---
 rtl/rotary_ctrl_pkg.sv | 20 ++
 rtl/rotary_step_calc.sv | 51 +++++
 rtl/rotary_value_ctrl.sv | 156 +++++++++++++++
 tb/tb_rotary_value_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_ctrl_pkg.sv
// Shared types and elaboration helpers for the rotary setpoint controller.
package rotary_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REQ    = 2'd2
    } state_e;

    // Number of distinct values in the inclusive range [min_val, max_val].
    function automatic int span(input int min_val, input int max_val);
        return max_val - min_val + 1;
    endfunction

    // Bits needed for a counter that must hold max_count (never less than 1).
    function automatic int cnt_w(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rotary_step_calc.sv
// Combinational next-value calculation: one step up or down with clamp or wrap.
module rotary_step_calc
    import rotary_ctrl_pkg::*;
#(
    parameter int VALUE_W = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 99,
    parameter int WRAP    = 0
) (
    input  logic [VALUE_W-1:0] value_i,
    input  logic               dir_i,
    input  logic [VALUE_W-1:0] step_i,
    output logic [VALUE_W-1:0] next_o
);

    // One extra bit keeps value+step and min+step free of overflow.
    localparam int XW = VALUE_W + 1;
    localparam logic [XW-1:0] MIN_X  = XW'(MIN_VAL);
    localparam logic [XW-1:0] MAX_X  = XW'(MAX_VAL);
    localparam logic [XW-1:0] SPAN_X = XW'(span(MIN_VAL, MAX_VAL));

    logic [XW-1:0] val_x;
    logic [XW-1:0] step_x;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] floor_x;
    logic [XW-1:0] res_x;

    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        val_x   = {1'b0, value_i};
        step_x  = {1'b0, step_i};
        sum_x   = val_x + step_x;
        floor_x = MIN_X + step_x;
        res_x   = val_x;
        if (dir_i) begin
            if (sum_x > MAX_X) begin
                res_x = (WRAP != 0) ? (sum_x - SPAN_X) : MAX_X;
            end else begin
                res_x = sum_x;
            end
        end else begin
            if (val_x < floor_x) begin
                res_x = (WRAP != 0) ? (val_x + SPAN_X - step_x) : MIN_X;
            end else begin
                res_x = val_x - step_x;
            end
        end
        next_o = VALUE_W'(res_x);
    end

endmodule

// File: rtl/rotary_value_ctrl.sv
// Bounded setpoint driven by encoder pulses, with one display update per settled change.
// Build option ROTARY_VALUE_CTRL_ACCEL_EN: larger steps while the encoder is rotated quickly.
module rotary_value_ctrl
    import rotary_ctrl_pkg::*;
#(
    parameter int VALUE_W       = 8,
    parameter int MIN_VAL       = 0,
    parameter int MAX_VAL       = 99,
    parameter int RESET_VAL     = 50,
    parameter int WRAP          = 0,
    parameter int SETTLE_CYCLES = 1000,
    parameter int ACCEL_WINDOW  = 5000,
    parameter int ACCEL_STEP    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_pulse,
    input  logic               dec_pulse,
    output logic [VALUE_W-1:0] value,
    output logic               upd_req,
    output logic [VALUE_W-1:0] upd_value,
    input  logic               upd_ack,
    output logic               dirty
);

    localparam int CNT_W = cnt_w(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VALUE_W-1:0] VAL_RST  = VALUE_W'(RESET_VAL);

    state_e             state_q;
    logic [VALUE_W-1:0] value_q;
    logic [VALUE_W-1:0] value_d;
    logic [VALUE_W-1:0] upd_value_q;
    logic               upd_req_q;
    logic               dirty_q;
    logic               acked_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               pulse_up;
    logic               pulse_any;
    logic               changed;
    logic [VALUE_W-1:0] step;
    logic [VALUE_W-1:0] calc_next;

    // Simultaneous inc and dec cancel and are treated as no pulse at all.
    assign pulse_up  = inc_pulse & ~dec_pulse;
    assign pulse_any = inc_pulse ^ dec_pulse;

`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
    localparam int GAP_W = cnt_w(ACCEL_WINDOW);
    localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW);

    logic [GAP_W-1:0] gap_q;

    // Starts saturated so the first pulse after reset is always a single step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= GAP_SAT;
        end else if (pulse_any) begin
            gap_q <= '0;
        end else if (gap_q < GAP_SAT) begin
            gap_q <= gap_q + GAP_W'(1);
        end
    end

    assign step = (gap_q < GAP_SAT) ? VALUE_W'(ACCEL_STEP) : VALUE_W'(1);
`else
    logic unused_accel;
    assign unused_accel = ^{32'(ACCEL_WINDOW), 32'(ACCEL_STEP)};
    assign step = VALUE_W'(1);
`endif

    rotary_step_calc #(
        .VALUE_W (VALUE_W),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .WRAP    (WRAP)
    ) u_step_calc (
        .value_i (value_q),
        .dir_i   (pulse_up),
        .step_i  (step),
        .next_o  (calc_next)
    );

    always_comb begin
        value_d = value_q;
        changed = 1'b0;
        if (pulse_any) begin
            value_d = calc_next;
            changed = (calc_next != value_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SETTLE;
            value_q     <= VAL_RST;
            upd_value_q <= VAL_RST;
            upd_req_q   <= 1'b0;
            dirty_q     <= 1'b1;
            acked_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            value_q <= value_d;
            case (state_q)
                IDLE: begin
                    if (changed) begin
                        dirty_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        dirty_q <= 1'b1;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        dirty_q <= 1'b0;
                        cnt_q   <= '0;
                        // Changes that cancelled back to the displayed value need no update.
                        if (acked_q && (value_q == upd_value_q)) begin
                            state_q <= IDLE;
                        end else begin
                            upd_value_q <= value_q;
                            upd_req_q   <= 1'b1;
                            state_q     <= REQ;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                REQ: begin
                    if (changed) begin
                        dirty_q <= 1'b1;
                    end
                    if (upd_ack) begin
                        upd_req_q <= 1'b0;
                        acked_q   <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= (dirty_q || changed) ? SETTLE : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign value     = value_q;
    assign upd_req   = upd_req_q;
    assign upd_value = upd_value_q;
    assign dirty     = dirty_q;

endmodule

// File: tb/tb_rotary_value_ctrl.sv
// Directed bench for rotary_value_ctrl: reset update, settle/coalesce, saturation, handshake, wrap/accel.
module tb_rotary_value_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] value;
    logic [7:0] upd_value;
    logic       upd_req;
    logic       dirty;

    logic       w_inc = 1'b0;
    logic       w_dec = 1'b0;
    logic       w_ack = 1'b0;
    logic [7:0] w_value;
    logic [7:0] w_upd_value;
    logic       w_upd_req;
    logic       w_dirty;

    int total = 0;
    int bad = 0;
    int req_rises = 0;

`ifdef ROTARY_VALUE_CTRL_ACCEL_EN
    localparam int W_E2 = 3;
    localparam int W_E3 = 8;
    localparam int W_E4 = 3;
    localparam int W_E5 = 2;
`else
    localparam int W_E2 = 99;
    localparam int W_E3 = 0;
    localparam int W_E4 = 99;
    localparam int W_E5 = 98;
`endif

    always #5 clk = ~clk;

    rotary_value_ctrl #(
        .VALUE_W(8), .MIN_VAL(0), .MAX_VAL(99), .RESET_VAL(50), .WRAP(0),
        .SETTLE_CYCLES(50), .ACCEL_WINDOW(10), .ACCEL_STEP(5)
    ) dut (
        .clk(clk), .rst(rst), .inc_pulse(inc), .dec_pulse(dec),
        .value(value), .upd_req(upd_req), .upd_value(upd_value),
        .upd_ack(ack), .dirty(dirty)
    );

    rotary_value_ctrl #(
        .VALUE_W(8), .MIN_VAL(0), .MAX_VAL(99), .RESET_VAL(97), .WRAP(1),
        .SETTLE_CYCLES(50), .ACCEL_WINDOW(100), .ACCEL_STEP(5)
    ) dut_wrap (
        .clk(clk), .rst(rst), .inc_pulse(w_inc), .dec_pulse(w_dec),
        .value(w_value), .upd_req(w_upd_req), .upd_value(w_upd_value),
        .upd_ack(w_ack), .dirty(w_dirty)
    );

    always @(posedge upd_req) req_rises++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic i, input logic d);
        inc = i;
        dec = d;
        @(negedge clk);
        inc = 1'b0;
        dec = 1'b0;
    endtask

    task automatic wpulse(input logic i, input logic d);
        w_inc = i;
        w_dec = d;
        @(negedge clk);
        w_inc = 1'b0;
        w_dec = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!upd_req && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int r0;

        cyc(3);
        check("rst_value", value, 50);
        check("rst_upd_value", upd_value, 50);
        check("rst_upd_req", upd_req, 0);
        check("rst_dirty", dirty, 1);
        rst = 1'b0;

        // Initial update: request appears after the 50th edge following reset release.
        cyc(49);
        check("init_req_not_yet", upd_req, 0);
        cyc(1);
        check("init_req_up", upd_req, 1);
        check("init_upd_value", upd_value, 50);
        check("init_req_count", req_rises, 1);
        do_ack();
        check("init_req_dropped", upd_req, 0);
        check("init_dirty_clear", dirty, 0);

        // Cancel-out and simultaneous pulses.
        r0 = req_rises;
        pulse(1'b1, 1'b0);
        check("cancel_inc_value", value, 51);
        check("cancel_inc_dirty", dirty, 1);
        cyc(19);
        pulse(1'b0, 1'b1);
        check("cancel_dec_value", value, 50);
        cyc(60);
        check("cancel_dirty", dirty, 0);
        check("cancel_no_req", req_rises, r0);
        check("cancel_req_low", upd_req, 0);
        pulse(1'b1, 1'b1);
        check("both_value", value, 50);
        check("both_dirty", dirty, 0);

        // Coalescing: ten pulses produce one request, 50 cycles after the last.
        cyc(19);
        r0 = req_rises;
        for (int i = 0; i < 10; i++) begin
            pulse(1'b1, 1'b0);
            if (i < 9) cyc(19);
        end
        check("coal_value", value, 60);
        wait_req(n);
        check("coal_latency", n, 50);
        check("coal_upd_value", upd_value, 60);
        check("coal_one_req", req_rises, r0 + 1);
        do_ack();
        check("coal_req_dropped", upd_req, 0);

        // Change during REQ: snapshot stays frozen, second request follows the ack.
        cyc(19);
        pulse(1'b1, 1'b0);
        wait_req(n);
        check("req_first_latency", n, 50);
        cyc(5);
        pulse(1'b0, 1'b1);
        cyc(19);
        pulse(1'b0, 1'b1);
        check("req_live_value", value, 59);
        check("req_frozen", upd_value, 61);
        check("req_held", upd_req, 1);
        check("req_dirty", dirty, 1);
        do_ack();
        check("req_ack_drop", upd_req, 0);
        wait_req(n);
        check("req_second_latency", n, 50);
        check("req_second_value", upd_value, 59);
        do_ack();

        // Saturation at the upper bound.
        for (int i = 0; i < 39; i++) begin
            cyc(19);
            pulse(1'b1, 1'b0);
        end
        check("sat_start_value", value, 98);
        wait_req(n);
        check("sat_start_latency", n, 50);
        do_ack();
        cyc(19);
        r0 = req_rises;
        pulse(1'b1, 1'b0);
        check("sat_value_1", value, 99);
        cyc(19);
        pulse(1'b1, 1'b0);
        check("sat_value_2", value, 99);
        cyc(19);
        pulse(1'b1, 1'b0);
        check("sat_value_3", value, 99);
        wait_req(n);
        check("sat_no_restart", n, 10);
        check("sat_upd_value", upd_value, 99);
        check("sat_one_req", req_rises, r0 + 1);
        do_ack();
        cyc(19);
        pulse(1'b1, 1'b0);
        check("sat_idle_value", value, 99);
        check("sat_idle_dirty", dirty, 0);
        cyc(60);
        check("sat_idle_no_req", req_rises, r0 + 1);

        // Wrap instance, pulse gaps 200/30/30/30/200 (the first gap is from reset).
        wpulse(1'b1, 1'b0);
        check("wrap_p1", w_value, 98);
        cyc(29);
        wpulse(1'b1, 1'b0);
        check("wrap_p2", w_value, W_E2);
        cyc(29);
        wpulse(1'b1, 1'b0);
        check("wrap_p3", w_value, W_E3);
        cyc(29);
        wpulse(1'b0, 1'b1);
        check("wrap_p4", w_value, W_E4);
        cyc(199);
        wpulse(1'b0, 1'b1);
        check("wrap_p5", w_value, W_E5);
        check("wrap_frozen", w_upd_value, 97);
        check("wrap_req_held", w_upd_req, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
